// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package cpu_pkg;

    localparam int PC_WIDTH    = 8;
    localparam int INSTR_WIDTH = 16;
    localparam int WAIT_LIMIT  = 15;

    localparam logic [PC_WIDTH-1:0] PC_STEP      = PC_WIDTH'(2);
    localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DELIVER,
        HALT,
        ERROR
    } fetch_state_t;

    // Source selected for the next program counter value.
    typedef enum logic [1:0] {
        PC_HOLD,
        PC_ADV,
        PC_JUMP
    } pc_sel_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/ack bus plus the decode-side valid/ready buffer.
interface pc_fetch_sequencer_if;
    import cpu_pkg::*;

    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;

    // Sequencer side.
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready
    );

    // Memory and decode side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_next_calc.sv
// Next-PC select (hold / sequential step / aligned target) and misalignment detect.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [PC_WIDTH-1:0] pc,
    input  pc_sel_t             sel,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                misaligned
);

    // Pick the next PC; targets always land on an instruction boundary.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        pc_next = pc;
        unique case (sel)
            PC_HOLD: pc_next = pc;
            PC_ADV:  pc_next = pc + PC_STEP;
            PC_JUMP: pc_next = {target[PC_WIDTH-1:1], 1'b0};
            default: pc_next = pc;
        endcase
    end

    assign misaligned = target[0];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter, fetch FSM, timeout counter and single-entry instruction buffer.
module pc_fetch_sequencer
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  halt_req,
    input  logic                  branch_valid,
    input  logic [PC_WIDTH-1:0]   branch_target,
    pc_fetch_sequencer_if.master  bus,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted,
    output logic                  fetch_err,
    output logic                  align_err
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

    fetch_state_t        state, state_n;
    pc_sel_t             pc_sel;
    logic [PC_WIDTH-1:0] pc_n, calc_target;
    logic [PC_WIDTH-1:0] kill_target, kill_target_n;
    logic                kill, kill_n;
    logic                misaligned;
    logic                load_buf, err_set;
    logic [WAIT_W-1:0]   wait_cnt;

    // A branch always supplies the target; otherwise a pending kill restores its saved one.
    assign calc_target = branch_valid ? branch_target : kill_target;

    pc_next_calc u_pc_next_calc (
        .pc         (pc),
        .sel        (pc_sel),
        .target     (calc_target),
        .pc_next    (pc_n),
        .misaligned (misaligned)
    );

    // Next-state, PC select, kill bookkeeping and buffer load decisions.
    always_comb begin
        state_n       = state;
        pc_sel        = PC_HOLD;
        kill_n        = kill;
        kill_target_n = kill_target;
        load_buf      = 1'b0;
        err_set       = 1'b0;
        unique case (state)
            IDLE: begin
                if (branch_valid)
                    pc_sel = PC_JUMP;
                else if (run)
                    state_n = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    if (branch_valid || kill) begin
                        // Returned data belongs to a squashed path: drop it and refetch.
                        pc_sel = PC_JUMP;
                        kill_n = 1'b0;
                    end else begin
                        pc_sel   = PC_ADV;
                        load_buf = 1'b1;
                        state_n  = DELIVER;
                    end
                end else begin
                    // Address must stay stable until ack, so the redirect is deferred.
                    if (branch_valid) begin
                        kill_n        = 1'b1;
                        kill_target_n = {branch_target[PC_WIDTH-1:1], 1'b0};
                    end
                    if (wait_cnt == WAIT_W'(WAIT_LIMIT - 1)) begin
                        state_n = ERROR;
                        err_set = 1'b1;
                    end
                end
            end
            DELIVER: begin
                if (branch_valid) begin
                    pc_sel  = PC_JUMP;
                    state_n = FETCH;
                end else if (bus.instr_ready) begin
                    state_n = halt_req ? HALT : FETCH;
                end
            end
            HALT: begin
                if (branch_valid)
                    pc_sel = PC_JUMP;
                else if (!halt_req && run)
                    state_n = FETCH;
            end
            ERROR: state_n = ERROR;
            default: state_n = IDLE;
        endcase
    end

    // State, PC, buffer, timeout counter and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_VECTOR;
            kill         <= 1'b0;
            kill_target  <= '0;
            wait_cnt     <= '0;
            bus.instr    <= '0;
            bus.instr_pc <= '0;
            fetch_err    <= 1'b0;
            align_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state       <= state_n;
            pc          <= pc_n;
            kill        <= kill_n;
            kill_target <= kill_target_n;
            wait_cnt    <= (state == FETCH && !bus.imem_ack) ? wait_cnt + 1'b1 : '0;
            if (load_buf) begin
                bus.instr    <= bus.imem_rdata;
                bus.instr_pc <= pc;
            end
            if (err_set)
                fetch_err <= 1'b1;
            if (branch_valid && misaligned && state != ERROR)
                align_err <= 1'b1;
        end
    end

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state == DELIVER);
    assign halted          = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer.
module tb_pc_fetch_sequencer;
    import cpu_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                run;
    logic                halt_req;
    logic                branch_valid;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] pc;
    logic                halted;
    logic                fetch_err;
    logic                align_err;

    int total = 0;
    int bad   = 0;

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .halt_req      (halt_req),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .bus           (bus),
        .pc            (pc),
        .halted        (halted),
        .fetch_err     (fetch_err),
        .align_err     (align_err)
    );

    always #5 clk = ~clk;

    // Memory model: each word tags its own address in the low byte.
    always_comb bus.imem_rdata = {8'hC3, bus.imem_addr};

    // Advance one cycle, ending on the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; halt_req = 1'b0; branch_valid = 1'b0;
        branch_target = '0; bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; halt_req = 1'b0; branch_valid = 1'b0;
        branch_target = '0; bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        total++; if (bus.instr !== 16'h0000 || bus.instr_pc !== 8'h00) begin bad++;
            $display("FAIL reset_buf: got instr=%h pc=%h want 0000/00", bus.instr, bus.instr_pc); end
        total++; if ({halted, fetch_err, align_err} !== 3'b000) begin bad++;
            $display("FAIL reset_flags: got %b want 000", {halted, fetch_err, align_err}); end
        reset = 1'b1;
        tick();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL idle_quiet: req got %b want 0", bus.imem_req); end
    endtask

    task automatic test_sequential();
        logic [PC_WIDTH-1:0] exp;
        do_reset();
        run = 1'b1; bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp = PC_WIDTH'(2 * i);
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp) begin bad++;
                $display("FAIL seq_fetch%0d: got req=%b addr=%h want 1/%h", i, bus.imem_req, bus.imem_addr, exp); end
            tick();
            total++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_pc !== exp) begin bad++;
                $display("FAIL seq_deliver%0d: got valid=%b req=%b ipc=%h want 1/0/%h",
                         i, bus.instr_valid, bus.imem_req, bus.instr_pc, exp); end
            total++; if (bus.instr !== {8'hC3, exp}) begin bad++;
                $display("FAIL seq_instr%0d: got %h want %h", i, bus.instr, {8'hC3, exp}); end
            tick();
        end
        total++; if (pc !== 8'h08) begin bad++; $display("FAIL seq_pc_end: got %h want 08", pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        branch_valid = 1'b1; branch_target = 8'hFE;
        tick();
        branch_valid = 1'b0;
        total++; if (pc !== 8'hFE || bus.imem_req !== 1'b0) begin bad++;
            $display("FAIL idle_branch: got pc=%h req=%b want fe/0", pc, bus.imem_req); end
        run = 1'b1; bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
        tick();
        total++; if (bus.imem_addr !== 8'hFE) begin bad++; $display("FAIL wrap_addr: got %h want fe", bus.imem_addr); end
        tick();
        total++; if (bus.instr_pc !== 8'hFE || pc !== 8'h00) begin bad++;
            $display("FAIL wrap_pc: got ipc=%h pc=%h want fe/00", bus.instr_pc, pc); end
        tick();
        total++; if (bus.imem_addr !== 8'h00 || fetch_err !== 1'b0 || align_err !== 1'b0) begin bad++;
            $display("FAIL wrap_next: got addr=%h ferr=%b aerr=%b want 00/0/0", bus.imem_addr, fetch_err, align_err); end
    endtask

    task automatic test_branch_kill_and_deliver();
        do_reset();
        branch_valid = 1'b1; branch_target = 8'h10;
        tick();
        branch_valid = 1'b0; run = 1'b1; bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
        tick();
        total++; if (bus.imem_addr !== 8'h10) begin bad++; $display("FAIL kill_start: got %h want 10", bus.imem_addr); end
        branch_valid = 1'b1; branch_target = 8'h40;
        tick();
        branch_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h10 || bus.instr_valid !== 1'b0) begin bad++;
                $display("FAIL kill_hold%0d: got req=%b addr=%h valid=%b want 1/10/0",
                         i, bus.imem_req, bus.imem_addr, bus.instr_valid); end
            if (i == 0) tick();
        end
        bus.imem_ack = 1'b1;
        tick();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40 || bus.instr_valid !== 1'b0) begin bad++;
            $display("FAIL kill_redirect: got req=%b addr=%h valid=%b want 1/40/0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid); end
        bus.instr_ready = 1'b0;
        tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h40 || align_err !== 1'b0) begin bad++;
            $display("FAIL kill_deliver: got valid=%b ipc=%h aerr=%b want 1/40/0",
                     bus.instr_valid, bus.instr_pc, align_err); end
        tick();
        total++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin bad++;
            $display("FAIL buf_hold: got valid=%b req=%b want 1/0", bus.instr_valid, bus.imem_req); end
        branch_valid = 1'b1; branch_target = 8'h41;
        tick();
        branch_valid = 1'b0;
        total++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) begin bad++;
            $display("FAIL flush: got valid=%b req=%b addr=%h want 0/1/40",
                     bus.instr_valid, bus.imem_req, bus.imem_addr); end
        total++; if (align_err !== 1'b1) begin bad++; $display("FAIL align_err: got %b want 1", align_err); end
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1; bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
        tick();
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            total++; if (bus.imem_req !== 1'b1 || fetch_err !== 1'b0) begin bad++;
                $display("FAIL wait%0d: got req=%b ferr=%b want 1/0", i, bus.imem_req, fetch_err); end
            tick();
        end
        total++; if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin bad++;
            $display("FAIL timeout: got ferr=%b req=%b valid=%b want 1/0/0", fetch_err, bus.imem_req, bus.instr_valid); end
        bus.imem_ack = 1'b1; branch_valid = 1'b1; branch_target = 8'h30;
        tick();
        branch_valid = 1'b0;
        tick();
        total++; if (pc !== 8'h00 || bus.imem_req !== 1'b0 || fetch_err !== 1'b1) begin bad++;
            $display("FAIL error_sticky: got pc=%h req=%b ferr=%b want 00/0/1", pc, bus.imem_req, fetch_err); end
        reset = 1'b0;
        #1;
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL error_clear: got %b want 0", fetch_err); end
    endtask

    task automatic test_halt_and_async_reset();
        do_reset();
        branch_valid = 1'b1; branch_target = 8'h20;
        tick();
        branch_valid = 1'b0; run = 1'b1; halt_req = 1'b1; bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
        tick();
        total++; if (bus.imem_addr !== 8'h20 || bus.imem_req !== 1'b1) begin bad++;
            $display("FAIL halt_fetch: got addr=%h req=%b want 20/1", bus.imem_addr, bus.imem_req); end
        tick();
        total++; if (bus.instr_pc !== 8'h20 || bus.instr_valid !== 1'b1) begin bad++;
            $display("FAIL halt_deliver: got ipc=%h valid=%b want 20/1", bus.instr_pc, bus.instr_valid); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (halted !== 1'b1 || bus.imem_req !== 1'b0 || pc !== 8'h22) begin bad++;
                $display("FAIL halted%0d: got halted=%b req=%b pc=%h want 1/0/22", i, halted, bus.imem_req, pc); end
        end
        halt_req = 1'b0;
        tick();
        total++; if (halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h22) begin bad++;
            $display("FAIL resume: got halted=%b req=%b addr=%h want 0/1/22", halted, bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b0 || pc !== 8'h00) begin bad++;
            $display("FAIL async_reset: got req=%b pc=%h want 0/00", bus.imem_req, pc); end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_branch_kill_and_deliver();
        test_timeout();
        test_halt_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Sequences the 8-bit program counter and the instruction-memory fetch for the RISC core. Owns the PC value, issues one request per instruction over a req/ack handshake, and holds each fetched instruction in a single-entry output buffer for decode (valid/ready). Handles branch redirects, a fetch timeout and halt/run control, replacing the free-running PC-plus-2 update path.

Parameters:
PC_WIDTH, 8, program counter / instruction address width
INSTR_WIDTH, 16, instruction word width
PC_STEP, 2, byte increment per sequential instruction
RESET_VECTOR, 8'h00, PC value after reset
WAIT_LIMIT, 15, max FETCH cycles without ack before error

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  start/resume fetching
halt_req  input  1  stop at next instruction boundary (level)
branch_valid  input  1  redirect request, one-cycle pulse
branch_target  input  PC_WIDTH  redirect address
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_WIDTH  fetch address (equals pc)
imem_ack  input  1  memory response valid this cycle
imem_rdata  input  INSTR_WIDTH  instruction word, valid with imem_ack
instr_valid  output  1  buffered instruction available
instr_ready  input  1  decode accepts instruction
instr  output  INSTR_WIDTH  buffered instruction
instr_pc  output  PC_WIDTH  address of buffered instruction
pc  output  PC_WIDTH  current fetch PC
halted  output  1  high in HALT state
fetch_err  output  1  sticky timeout flag
align_err  output  1  sticky flag: branch_target bit 0 was 1

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, pc=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_err=0, align_err=0, kill=0, wait count=0. imem_req drops immediately; any in-flight fetch is abandoned.
- States: IDLE, FETCH, DELIVER, HALT, ERROR.
- IDLE: outputs quiet. run=1 -> FETCH. halt_req ignored.
- FETCH: imem_req=1, imem_addr=pc. Address is held stable until ack. Wait count increments each cycle without ack.
  - Ack without kill: instr<=imem_rdata, instr_pc<=pc, pc<=pc+PC_STEP (mod 2^PC_WIDTH, so 8'hFE wraps to 8'h00 with no flag). Next state DELIVER. Minimum latency is ack in the first FETCH cycle, with instr_valid high the next cycle.
  - Wait count reaching WAIT_LIMIT without ack -> ERROR, fetch_err=1.
- DELIVER: instr_valid=1, imem_req=0. On instr_valid&instr_ready the transfer completes. If halt_req=1 -> HALT, else -> FETCH.
- HALT: halted=1, no requests. When halt_req=0 and run=1 -> FETCH at the unchanged pc.
- ERROR: terminal until reset. imem_req=0, instr_valid=0, fetch_err=1.
- Branch handling (branch_valid=1), applied to any state except ERROR:
  - pc<=branch_target with bit 0 forced to 0. If bit 0 was 1, align_err<=1.
  - In FETCH before ack: imem_req and imem_addr stay unchanged until ack. kill<=1 and the target is saved. On ack the data is discarded, pc<=saved target, kill<=0, and the block stays in FETCH with a new request the next cycle. The wait count restarts.
  - In FETCH with ack in the same cycle: the data is discarded, pc<=target, and the block stays in FETCH.
  - In DELIVER: a transfer in the same cycle still completes. The buffer is flushed (instr_valid=0 next cycle), pc<=target, next state FETCH. Branch has priority over halt_req.
  - In IDLE or HALT: only pc is updated; the state is unchanged.
- A new fetch is never issued while the buffer holds an unaccepted instruction.
- Back-to-back minimum is 2 cycles per instruction (FETCH with immediate ack, then DELIVER with ready=1).

Decomposition:
- Shared package cpu_pkg: state enum (IDLE, FETCH, DELIVER, HALT, ERROR), PC_WIDTH, INSTR_WIDTH, RESET_VECTOR, PC_STEP.
- One sub-module, pc_next_calc: combinational next-PC select (hold / +PC_STEP / aligned branch target) plus the align_err detect. The FSM, wait counter and buffer stay in the top module.

Test Plan:
- Reset then run=1, imem_ack=1 every FETCH cycle, instr_ready=1 -> imem_addr 00,02,04,06 on alternate cycles; instr_pc matches; pc=08 after 4 instructions.
- pc=8'hFE with ack -> instr_pc=FE, next imem_addr=00, no error flag.
- Branch pulse to 8'h40 in FETCH two cycles before ack at addr 10 -> imem_addr stays 10 until ack; no instr_valid for that data; next request at 40.
- branch_target=8'h41 in DELIVER with instr_ready=0 -> instr_valid drops next cycle, next imem_addr=40, align_err=1.
- imem_ack held 0 for 15 FETCH cycles -> fetch_err=1, imem_req=0, state ERROR persists until reset=0.
- halt_req=1 with transfer in DELIVER at instr_pc=20 -> halted=1, no req. Then halt_req=0 with run=1 -> fetch resumes at 22. Asserting reset=0 mid-FETCH drops imem_req the same cycle and sets pc=00.
